// File: rtl/async_oneway_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : async_oneway_receiver_pkg
// Description : Shared constants, the receiver FSM state type and a small
//               helper function for the one-way REQ/ACK chunk receiver.
// Contents    : c_MESSAGE_SIZE, c_CHUNK_W, c_SYNC_STAGES, c_TIMEOUT defaults;
//               rx_state_t; ceil_div().
// Revision    : 1.0 - initial release
// ============================================================================
package async_oneway_receiver_pkg;

    localparam int c_MESSAGE_SIZE = 16;
    localparam int c_CHUNK_W      = 6;
    localparam int c_SYNC_STAGES  = 2;
    localparam int c_TIMEOUT      = 1024;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } rx_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/async_oneway_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : async_oneway_receiver_if
// Description : Board-to-board REQ/ACK link plus the reassembled-datagram
//               outputs, bundled for the receiver.
// Signals     : REQ, DIN      - from transmitter (DIN bundled with REQ)
//               ACK           - back to transmitter
//               datagram, valid, frame_err - to the output interface
// Modports    : master - transmitter/consumer side; slave - receiver side.
// Revision    : 1.0 - initial release
// ============================================================================
interface async_oneway_receiver_if
    import async_oneway_receiver_pkg::*;
#(
    parameter int MESSAGE_SIZE = c_MESSAGE_SIZE,
    parameter int CHUNK_W      = c_CHUNK_W
) ();

    logic                    REQ;
    logic [CHUNK_W-1:0]      DIN;
    logic                    ACK;
    logic [MESSAGE_SIZE-1:0] datagram;
    logic                    valid;
    logic                    frame_err;

    modport master (
        output REQ, DIN,
        input  ACK, datagram, valid, frame_err
    );

    modport slave (
        input  REQ, DIN,
        output ACK, datagram, valid, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/async_oneway_receiver_sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : async_oneway_receiver_sync_ff
// Description : Parameterised-depth single-bit synchroniser (sync_ff). Also
//               suitable for the transmitter's ACK input.
// Ports       : clk, rst - clock and synchronous active-high reset
//               d_i       - asynchronous input bit
//               q_o       - synchronised output (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module async_oneway_receiver_sync_ff #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d_i,
    output logic      q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/async_oneway_receiver.sv
`default_nettype none
// ============================================================================
// Module      : async_oneway_receiver
// Description : Receiving end of the 4-phase REQ/ACK datagram link.
//               Synchronises REQ, captures one DIN chunk per handshake,
//               reassembles MESSAGE_SIZE bits MSB-chunk-first and pulses
//               valid when a frame completes. A partial frame idle for
//               TIMEOUT cycles is dropped with a frame_err pulse.
// Ports       : clk, rst - clock and synchronous active-high reset
//               bus       - async_oneway_receiver_if.slave
//                           (REQ, DIN in; ACK, datagram, valid, frame_err out)
// Revision    : 1.0 - initial release
// ============================================================================
module async_oneway_receiver
    import async_oneway_receiver_pkg::*;
#(
    parameter int MESSAGE_SIZE = c_MESSAGE_SIZE,
    parameter int CHUNK_W      = c_CHUNK_W,
    parameter int SYNC_STAGES  = c_SYNC_STAGES,
    parameter int TIMEOUT      = c_TIMEOUT
) (
    input  wire logic               clk,
    input  wire logic               rst,
    async_oneway_receiver_if.slave  bus
);

    localparam int NUM_CHUNKS = ceil_div(MESSAGE_SIZE, CHUNK_W);
    localparam int SR_W       = NUM_CHUNKS * CHUNK_W;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int IDLE_W     = $clog2(TIMEOUT + 1);

    logic                    req_s;
    rx_state_t               state_q,    state_d;
    logic                    ack_q,      ack_d;
    logic [SR_W-1:0]         sr_q,       sr_d;
    logic [CNT_W-1:0]        cnt_q,      cnt_d;
    logic [IDLE_W-1:0]       idle_q,     idle_d;
    logic [MESSAGE_SIZE-1:0] datagram_q, datagram_d;
    logic                    valid_q,    valid_d;
    logic                    ferr_q,     ferr_d;
    logic [SR_W-1:0]         sr_next;

    async_oneway_receiver_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.REQ),
        .q_o (req_s)
    );

    // Left shift: the oldest chunk ends up in the most significant position.
    assign sr_next = SR_W'({sr_q, bus.DIN});

    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        datagram_d = datagram_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_s) begin
                    // DIN is bundled with REQ, so it is stable once req_s is seen.
                    state_d = WAIT_LOW;
                    ack_d   = 1'b1;
                    sr_d    = sr_next;
                    idle_d  = '0;
                    if (cnt_q == CNT_W'(NUM_CHUNKS - 1)) begin
                        // Pad bits above MESSAGE_SIZE in the first chunk are dropped.
                        datagram_d = sr_next[MESSAGE_SIZE-1:0];
                        valid_d    = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cnt_q != '0) begin
                    // Only a started frame can go stale; idle between frames is legal.
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        cnt_d  = '0;
                        sr_d   = '0;
                        idle_d = '0;
                        ferr_d = 1'b1;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end
            WAIT_LOW: begin
                // A stuck-high REQ simply holds ACK; the idle counter is frozen here.
                if (!req_s) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            sr_q       <= '0;
            cnt_q      <= '0;
            idle_q     <= '0;
            datagram_q <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            datagram_q <= datagram_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bus.ACK       = ack_q;
    assign bus.datagram  = datagram_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;

endmodule
`default_nettype wire
